// File: rtl/data_mem_pkg.sv
// Shared encodings and helpers for the byte-addressed data memory controller.
package data_mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    localparam int WAIT_W = 4;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_IDLE  = 2'd1,
        ST_BUSY  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    // Access width in bytes; the invalid encoding reports a full word so range math stays bounded.
    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            SZ_BYTE: size_bytes = 3'd1;
            SZ_HALF: size_bytes = 3'd2;
            default: size_bytes = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/data_mem_extend.sv
// Load lane select and sign/zero extension from a big-endian memory word.
module data_mem_extend
    import data_mem_pkg::*;
(
    input  logic [31:0] raw_word,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [31:0] load_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (addr_lo)
            2'd0:    byte_sel = raw_word[31:24];
            2'd1:    byte_sel = raw_word[23:16];
            2'd2:    byte_sel = raw_word[15:8];
            default: byte_sel = raw_word[7:0];
        endcase
        half_sel = addr_lo[1] ? raw_word[15:0] : raw_word[31:16];

        case (size)
            SZ_BYTE: load_data = is_unsigned ? {24'd0, byte_sel}
                                             : {{24{byte_sel[7]}}, byte_sel};
            SZ_HALF: load_data = is_unsigned ? {16'd0, half_sel}
                                             : {{16{half_sel[15]}}, half_sel};
            default: load_data = raw_word;
        endcase
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// Big-endian byte-addressed data memory with valid/ready requests, wait states,
// error reporting and a word-per-cycle clear sweep.
//
// state    | meaning
// CLEAR    | zeroing one word per cycle at clr_cnt, requests blocked
// IDLE     | ready for a request or a clear command
// BUSY     | request latched, counting down wait states, executes at zero
// RESP     | single-cycle response pulse
module data_mem_ctrl
    import data_mem_pkg::*;
#(
    parameter int ENTRIES     = 256,
    parameter int WAIT_STATES = 0,
    parameter int AW          = $clog2(ENTRIES)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [31:0] resp_rdata,
    input  logic        clr_req,
    output logic        init_done,
    input  logic [31:0] dbg_ram_addr,
    output logic [31:0] dbg_ram_data
);

    localparam int WW = AW - 2;
    localparam logic [WW-1:0] CLR_LAST = WW'(ENTRIES / 4 - 1);

    logic [7:0] mem [ENTRIES];

    state_e              state_q, state_d;
    logic [WW-1:0]       clr_cnt_q, clr_cnt_d;
    logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic                we_q, we_d;
    logic [1:0]          size_q, size_d;
    logic                uns_q, uns_d;
    logic [31:0]         addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic                req_ready_q, req_ready_d;
    logic                resp_valid_q, resp_valid_d;
    logic                resp_err_q, resp_err_d;
    logic [31:0]         resp_rdata_q, resp_rdata_d;
    logic                init_done_q, init_done_d;

    logic [32:0]         acc_end;
    logic                acc_err;
    logic                exec;
    logic [WW-1:0]       acc_word;
    logic [31:0]         rd_word;
    logic [31:0]         ext_data;
    logic [WW-1:0]       dbg_word;

    logic [3:0]          lane_we;
    logic [7:0]          lane_data [4];
    logic [WW-1:0]       wr_word;

    assign acc_word = addr_q[AW-1:2];
    assign exec     = (state_q == ST_BUSY) && (wait_cnt_q == '0);

    // 33-bit end address so accesses near 2^32 cannot wrap back into range.
    always_comb begin
        acc_end = {1'b0, addr_q} + {30'd0, size_bytes(size_q)};
        acc_err = (size_q == 2'd3)
               || ((size_q == SZ_HALF) && addr_q[0])
               || ((size_q == SZ_WORD) && (addr_q[1:0] != 2'd0))
               || (acc_end > 33'(ENTRIES));
    end

    assign rd_word = {mem[{acc_word, 2'd0}], mem[{acc_word, 2'd1}],
                      mem[{acc_word, 2'd2}], mem[{acc_word, 2'd3}]};

    data_mem_extend u_extend (
        .raw_word    (rd_word),
        .addr_lo     (addr_q[1:0]),
        .size        (size_q),
        .is_unsigned (uns_q),
        .load_data   (ext_data)
    );

    assign dbg_word     = dbg_ram_addr[AW-1:2];
    assign dbg_ram_data = ({1'b0, dbg_ram_addr} < 33'(ENTRIES))
                        ? {mem[{dbg_word, 2'd0}], mem[{dbg_word, 2'd1}],
                           mem[{dbg_word, 2'd2}], mem[{dbg_word, 2'd3}]}
                        : 32'd0;

    // Lane 0 is the lowest byte address, i.e. the most significant byte.
    always_comb begin
        lane_we   = 4'h0;
        lane_data = '{default: 8'h00};
        wr_word   = acc_word;
        if (state_q == ST_CLEAR) begin
            lane_we = 4'hF;
            wr_word = clr_cnt_q;
        end else if (exec && we_q && !acc_err) begin
            case (size_q)
                SZ_BYTE: begin
                    lane_we[addr_q[1:0]]   = 1'b1;
                    lane_data[addr_q[1:0]] = wdata_q[7:0];
                end
                SZ_HALF: begin
                    lane_we[{addr_q[1], 1'b0}]   = 1'b1;
                    lane_we[{addr_q[1], 1'b1}]   = 1'b1;
                    lane_data[{addr_q[1], 1'b0}] = wdata_q[15:8];
                    lane_data[{addr_q[1], 1'b1}] = wdata_q[7:0];
                end
                default: begin
                    lane_we      = 4'hF;
                    lane_data[0] = wdata_q[31:24];
                    lane_data[1] = wdata_q[23:16];
                    lane_data[2] = wdata_q[15:8];
                    lane_data[3] = wdata_q[7:0];
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (lane_we[i]) begin
                mem[{wr_word, 2'(i)}] <= lane_data[i];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        clr_cnt_d    = clr_cnt_q;
        wait_cnt_d   = wait_cnt_q;
        we_d         = we_q;
        size_d       = size_q;
        uns_d        = uns_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        resp_err_d   = resp_err_q;
        resp_rdata_d = resp_rdata_q;

        case (state_q)
            ST_CLEAR: begin
                if (clr_cnt_q == CLR_LAST) begin
                    clr_cnt_d = '0;
                    state_d   = ST_IDLE;
                end else begin
                    clr_cnt_d = clr_cnt_q + 1'b1;
                end
            end
            ST_IDLE: begin
                // A request in the same cycle as clr_req takes priority.
                if (req_valid && req_ready_q) begin
                    we_d       = req_we;
                    size_d     = req_size;
                    uns_d      = req_unsigned;
                    addr_d     = req_addr;
                    wdata_d    = req_wdata;
                    wait_cnt_d = WAIT_W'(WAIT_STATES);
                    state_d    = ST_BUSY;
                end else if (clr_req) begin
                    clr_cnt_d = '0;
                    state_d   = ST_CLEAR;
                end
            end
            ST_BUSY: begin
                if (wait_cnt_q != '0) begin
                    wait_cnt_d = wait_cnt_q - 1'b1;
                end else begin
                    resp_err_d   = acc_err;
                    resp_rdata_d = (acc_err || we_q) ? 32'd0 : ext_data;
                    state_d      = ST_RESP;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        req_ready_d  = (state_d == ST_IDLE);
        resp_valid_d = (state_d == ST_RESP);
        init_done_d  = (state_d != ST_CLEAR);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_CLEAR;
            clr_cnt_q    <= '0;
            wait_cnt_q   <= '0;
            we_q         <= 1'b0;
            size_q       <= SZ_BYTE;
            uns_q        <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            req_ready_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
            init_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            clr_cnt_q    <= clr_cnt_d;
            wait_cnt_q   <= wait_cnt_d;
            we_q         <= we_d;
            size_q       <= size_d;
            uns_q        <= uns_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
            init_done_q  <= init_done_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_rdata = resp_rdata_q;
    assign init_done  = init_done_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: directed requests plus a per-cycle reference model compare.
module tb_data_mem_ctrl;
    import data_mem_pkg::*;

    localparam int ENTRIES = 256;
    localparam int WS      = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;
    logic        clr_req;
    logic        init_done;
    logic [31:0] dbg_ram_addr;
    logic [31:0] dbg_ram_data;

    int vectors     = 0;
    int miscompares = 0;

    data_mem_ctrl #(.ENTRIES(ENTRIES), .WAIT_STATES(WS)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_err     (resp_err),
        .resp_rdata   (resp_rdata),
        .clr_req      (clr_req),
        .init_done    (init_done),
        .dbg_ram_addr (dbg_ram_addr),
        .dbg_ram_data (dbg_ram_data)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, miscompares so far %0d", miscompares);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: actual %h required %h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0] mdl_mem [ENTRIES];

    function automatic int nbytes(input logic [1:0] sz);
        return 1 << sz;
    endfunction

    function automatic logic model_err(input logic [1:0] sz, input logic [31:0] a);
        longint last;
        last = {32'd0, a};
        last = last + nbytes(sz);
        if (sz == 2'd3) return 1'b1;
        if ((int'(a) % nbytes(sz)) != 0) return 1'b1;
        return last > ENTRIES;
    endfunction

    function automatic logic [31:0] model_load(input logic [1:0] sz, input logic uns,
                                               input logic [31:0] a);
        longint v;
        int n;
        n = nbytes(sz);
        v = 0;
        for (int i = 0; i < n; i++) v = (v << 8) | longint'(mdl_mem[int'(a) + i]);
        if (!uns && n < 4 && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
        return v[31:0];
    endfunction

    function automatic logic [31:0] model_dbg(input logic [31:0] a);
        int base;
        if ({32'd0, a} >= ENTRIES) return 32'd0;
        base = int'(a) & ~3;
        return {mdl_mem[base], mdl_mem[base + 1], mdl_mem[base + 2], mdl_mem[base + 3]};
    endfunction

    // Compare process: outputs are stable at the falling edge; inputs seen here
    // are the ones the next rising edge will act on.
    int          cyc = 0;
    int          idle_from = 32'h3fff_ffff;
    int          ready_from = 0;
    bit          clr_pending = 1'b0;
    bit          pend_valid = 1'b0;
    int          pend_due = 0;
    logic        pend_we, pend_err;
    logic [1:0]  pend_size;
    logic [31:0] pend_addr, pend_wdata, pend_rdata;

    initial begin
        bit exp_resp, exp_init, exp_ready;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                pend_valid  = 1'b0;
                clr_pending = 1'b1;
                idle_from   = cyc + 65;
                chk("rst_req_ready",  {31'd0, req_ready},  32'd0);
                chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
                chk("rst_init_done",  {31'd0, init_done},  32'd0);
            end else begin
                if (clr_pending && cyc >= idle_from) begin
                    foreach (mdl_mem[i]) mdl_mem[i] = 8'h00;
                    clr_pending = 1'b0;
                end
                exp_resp = pend_valid && (cyc == pend_due);
                if (exp_resp && pend_we && !pend_err) begin
                    for (int i = 0; i < nbytes(pend_size); i++)
                        mdl_mem[int'(pend_addr) + i] =
                            8'(pend_wdata >> (8 * (nbytes(pend_size) - 1 - i)));
                end
                exp_init  = (cyc >= idle_from);
                exp_ready = exp_init && !pend_valid && (cyc >= ready_from);
                chk("cyc_req_ready",  {31'd0, req_ready},  {31'd0, exp_ready});
                chk("cyc_init_done",  {31'd0, init_done},  {31'd0, exp_init});
                chk("cyc_resp_valid", {31'd0, resp_valid}, {31'd0, exp_resp});
                if (exp_resp) begin
                    chk("cyc_resp_err",   {31'd0, resp_err}, {31'd0, pend_err});
                    chk("cyc_resp_rdata", resp_rdata, pend_rdata);
                    pend_valid = 1'b0;
                    ready_from = cyc + 1;
                end
                if (exp_init) chk("cyc_dbg_data", dbg_ram_data, model_dbg(dbg_ram_addr));
                if (exp_ready) begin
                    if (req_valid) begin
                        pend_valid = 1'b1;
                        pend_due   = cyc + WS + 2;
                        pend_we    = req_we;
                        pend_size  = req_size;
                        pend_addr  = req_addr;
                        pend_wdata = req_wdata;
                        pend_err   = model_err(req_size, req_addr);
                        pend_rdata = (pend_err || req_we) ? 32'd0
                                   : model_load(req_size, req_unsigned, req_addr);
                    end else if (clr_req) begin
                        clr_pending = 1'b1;
                        idle_from   = cyc + 65;
                    end
                end
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                          input logic [31:0] a, input logic [31:0] wd, input logic with_clr,
                          output logic err, output logic [31:0] rd);
        int n;
        int lat;
        @(posedge clk); #1;
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = a;
        req_wdata    = wd;
        clr_req      = with_clr;
        n = 0;
        do begin @(negedge clk); n++; end while (!req_ready && n < 200);
        chk("accept_seen", {31'd0, req_ready}, 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        clr_req   = 1'b0;
        lat = 0;
        do begin @(negedge clk); lat++; end while (!resp_valid && lat < 50);
        chk("resp_latency", 32'(lat), 32'd4);
        err = resp_err;
        rd  = resp_rdata;
    endtask

    task automatic dbg_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
        @(posedge clk); #1;
        dbg_ram_addr = a;
        @(negedge clk);
        chk(name, dbg_ram_data, exp);
    endtask

    task automatic wait_init(output int cnt);
        cnt = 0;
        @(negedge clk);
        while (!init_done && cnt < 300) begin
            cnt++;
            chk("ready_low_in_clear", {31'd0, req_ready}, 32'd0);
            @(negedge clk);
        end
    endtask

    initial begin
        logic        e;
        logic [31:0] d;
        int          cnt;

        rst_n        = 1'b1;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_size     = SZ_BYTE;
        req_unsigned = 1'b0;
        req_addr     = 32'd0;
        req_wdata    = 32'd0;
        clr_req      = 1'b0;
        dbg_ram_addr = 32'h40;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        wait_init(cnt);
        chk("init_cycles_after_reset", 32'(cnt), 32'd64);
        dbg_chk("dbg_zero_40", 32'h40, 32'd0);
        dbg_chk("dbg_zero_fc", 32'hFC, 32'd0);

        do_req(1'b1, SZ_WORD, 1'b0, 32'h10, 32'h8123_4567, 1'b0, e, d);
        chk("sw10_err", {31'd0, e}, 32'd0);
        chk("sw10_rdata", d, 32'd0);
        dbg_chk("dbg_10", 32'h10, 32'h8123_4567);
        chk("mdl_pin_lb",   model_load(SZ_BYTE, 1'b0, 32'h10), 32'hFFFF_FF81);
        chk("mdl_pin_lhu",  model_load(SZ_HALF, 1'b1, 32'h12), 32'h0000_4567);
        chk("mdl_pin_err",  {31'd0, model_err(SZ_WORD, 32'hFE)}, 32'd1);
        chk("mdl_pin_ok",   {31'd0, model_err(SZ_BYTE, 32'hFF)}, 32'd0);

        do_req(1'b0, SZ_BYTE, 1'b0, 32'h10, 32'h0, 1'b0, e, d);
        chk("lb10", d, 32'hFFFF_FF81);
        do_req(1'b0, SZ_HALF, 1'b1, 32'h12, 32'h0, 1'b0, e, d);
        chk("lhu12", d, 32'h0000_4567);
        do_req(1'b0, SZ_HALF, 1'b0, 32'h10, 32'h0, 1'b0, e, d);
        chk("lh10", d, 32'hFFFF_8123);
        do_req(1'b0, SZ_BYTE, 1'b1, 32'h13, 32'h0, 1'b0, e, d);
        chk("lbu13", d, 32'h0000_0067);
        do_req(1'b0, SZ_WORD, 1'b1, 32'h10, 32'h0, 1'b0, e, d);
        chk("lw10", d, 32'h8123_4567);

        do_req(1'b0, SZ_HALF, 1'b0, 32'h11, 32'h0, 1'b0, e, d);
        chk("lh11_err", {31'd0, e}, 32'd1);
        chk("lh11_rdata", d, 32'd0);
        do_req(1'b1, SZ_WORD, 1'b0, 32'hFE, 32'hCAFE_F00D, 1'b0, e, d);
        chk("swfe_err", {31'd0, e}, 32'd1);
        chk("swfe_rdata", d, 32'd0);
        dbg_chk("dbg_fc_untouched", 32'hFC, 32'd0);
        do_req(1'b0, 2'd3, 1'b0, 32'h10, 32'h0, 1'b0, e, d);
        chk("size3_err", {31'd0, e}, 32'd1);
        chk("size3_rdata", d, 32'd0);
        do_req(1'b0, SZ_WORD, 1'b0, 32'h100, 32'h0, 1'b0, e, d);
        chk("lw100_err", {31'd0, e}, 32'd1);
        do_req(1'b1, SZ_BYTE, 1'b0, 32'hFF, 32'h1234_56A5, 1'b0, e, d);
        chk("sbff_err", {31'd0, e}, 32'd0);
        do_req(1'b0, SZ_BYTE, 1'b0, 32'hFF, 32'h0, 1'b0, e, d);
        chk("lbff", d, 32'hFFFF_FFA5);
        dbg_chk("dbg_fc_after_sb", 32'hFC, 32'h0000_00A5);
        do_req(1'b1, SZ_HALF, 1'b0, 32'h20, 32'h1234_BEEF, 1'b0, e, d);
        dbg_chk("dbg_20_half", 32'h20, 32'hBEEF_0000);
        dbg_chk("dbg_out_of_range", 32'h0000_0100, 32'd0);

        // Reset while a store is waiting out its wait states.
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = 1'b1; req_size = SZ_WORD;
        req_addr = 32'h30; req_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("rst_store_accept", {31'd0, req_ready}, 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("rst_store_busy_ready", {31'd0, req_ready}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_store_no_resp", {31'd0, resp_valid}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        wait_init(cnt);
        chk("init_cycles_after_midreset", 32'(cnt), 32'd64);
        dbg_chk("dbg_30_dropped", 32'h30, 32'd0);
        dbg_chk("dbg_10_cleared", 32'h10, 32'd0);

        // Request and clear together: request wins; then a lone clear.
        do_req(1'b1, SZ_WORD, 1'b0, 32'h40, 32'h1122_3344, 1'b0, e, d);
        do_req(1'b0, SZ_WORD, 1'b0, 32'h40, 32'h0, 1'b1, e, d);
        chk("req_wins_rdata", d, 32'h1122_3344);
        chk("req_wins_init", {31'd0, init_done}, 32'd1);
        @(posedge clk); #1;
        clr_req = 1'b1;
        @(negedge clk);
        chk("clr_from_idle", {31'd0, req_ready}, 32'd1);
        @(posedge clk); #1;
        clr_req = 1'b0;
        wait_init(cnt);
        chk("init_cycles_after_clr", 32'(cnt), 32'd64);
        dbg_chk("dbg_40_cleared", 32'h40, 32'd0);
        do_req(1'b0, SZ_WORD, 1'b0, 32'h40, 32'h0, 1'b0, e, d);
        chk("lw40_cleared", d, 32'd0);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
